timekeeper_core: RTL and testbench
==================================

// Module: timekeeper_core
// PURPOSE
//  Owns the running clock (hh:mm:ss) and the alarm time; receives adjusted values from the adjust-mode block and returns the current values to it.
//  Advances time at 1 Hz, freezes it while adjust mode is active, and reloads on exit from adjust mode.
//  Runs the alarm ring/snooze state machine that drives the buzzer.
// PARAMETERS
//  CLK_HZ      50000000  input clock frequency; prescaler terminal count = CLK_HZ-1
//  RING_SEC    60        seconds the alarm rings before auto-stop
//  SNOOZE_SEC  300       seconds spent in SNOOZE before ringing again
// PORTS
//  clk          in   1   system clock
//  RESET        in   1   reset; asynchronous, active-low
//  enADJ        in   1   adjust mode active (level)
//  hours12_24   in   1   1 = load hours from 12 h inputs, 0 = load from 24 h inputs
//  adjC12_IN    in   16  adjusted clock {hr 0..11, min 0..59}
//  adjC24_IN    in   16  adjusted clock {hr 0..23, min 0..59}
//  adjA12_IN    in   16  adjusted alarm {hr 0..11, min}
//  adjA24_IN    in   16  adjusted alarm {hr 0..23, min}
//  alarm_en     in   1   alarm arm switch (level, already synchronised)
//  stop_p       in   1   stop pulse (debounced and edge-detected, 1 cycle)
//  snooze_p     in   1   snooze pulse (debounced and edge-detected, 1 cycle)
//  dataC12_OUT  out  16  current {hr12, min}
//  dataC24_OUT  out  16  current {hr24, min}
//  dataA12_OUT  out  16  alarm {hr12, min}
//  dataA24_OUT  out  16  alarm {hr24, min}
//  sec          out  6   current seconds 0..59
//  pmC, pmA     out  1   clock / alarm hour >= 12
//  tick_1hz     out  1   1-cycle pulse per advanced second
//  buzz         out  1   alarm sounding
// BEHAVIOUR
//  Reset values: time 00:00:00 (pmC=0), alarm 23:59 (hr12=11, pmA=1), prescaler 0, FSM IDLE. All outputs are registered; buzz=0 and tick_1hz=0 at reset.
//  Prescaler:
//   - Counts 0..CLK_HZ-1 and wraps.
//   - tick_1hz=1 on the wrap cycle; sec/min/hr update on that same edge.
//   - While enADJ=1 the prescaler is held at 0, tick_1hz=0 and time is frozen.
//  Time wrap: sec 59->0 increments min; min 59->0 increments hr24; 23:59:59 -> 00:00:00.
//  12 h encoding:
//   - hr12 = hr24>=12 ? hr24-12 : hr24 (range 0..11); pm = (hr24>=12).
//   - Outputs are {8'(hr), 8'(min)}, binary, upper bits zero.
//  Load:
//   - enADJ is registered; a 1->0 transition (load cycle) latches the adjusted values on the next edge.
//   - hours12_24=0: hr24 <- adjC24_IN[15:8]. hours12_24=1: hr24 <- adjC12_IN[15:8] + (pmC ? 12 : 0), i.e. the pre-adjust pmC is kept.
//   - min <- adjC*_IN[7:0]; sec <- 0; prescaler <- 0.
//   - The alarm loads identically from adjA*, using pmA.
//   - Out-of-range loaded values (min>59, hr24>23, hr12>11) are clamped to the maximum legal value.
//  Alarm FSM states: IDLE, RING, SNOOZE.
//   - IDLE->RING: on the tick that makes sec=0, when alarm_en=1 and {hr24,min} equals the alarm. A load never triggers RING.
//   - RING: buzz=1; a seconds counter runs. stop_p -> IDLE. snooze_p -> SNOOZE (snooze counter <- SNOOZE_SEC). Counter reaches RING_SEC -> IDLE.
//   - SNOOZE: buzz=0; the counter decrements on each tick; reaching 0 -> RING (ring counter cleared). stop_p -> IDLE.
//   - From any state, alarm_en=0 or rising enADJ forces IDLE on the next edge.
//   - stop_p and snooze_p in the same cycle: stop wins.
//   - RESET mid-ring: buzz drops immediately (asynchronous).
// TESTING
//  (CLK_HZ=4 for sim.) Release reset, run 4 clk -> tick_1hz once, sec=1; dataC24_OUT=16'h0000 upper, min 0.
//  Preload 23:59:59 via load (sec then counts 59 s) -> next tick gives dataC24_OUT={8'd0,8'd0}, sec=0, pmC=0.
//  pmC=1 (14:xx), hours12_24=1, adjC12_IN={8'd3,8'd20}, enADJ 1->0 -> dataC24_OUT={8'd15,8'd20}, sec=0.
//  Alarm 07:30, alarm_en=1, time reaches 07:30:00 -> buzz=1 on that tick; no stop -> buzz=0 after RING_SEC ticks.
//  In RING, snooze_p -> buzz=0 for SNOOZE_SEC ticks, then buzz=1; stop_p and snooze_p together -> IDLE, buzz=0.
//  enADJ=1 for 20 clk -> sec unchanged, tick_1hz never asserted; raise enADJ during RING -> buzz=0 next cycle.

Source files
------------

// File: rtl/timekeeper_core.sv
// Running hh:mm:ss clock and alarm time with adjust-mode load, 1 Hz prescaler,
// and the alarm ring/snooze state machine that drives the buzzer.
module timekeeper_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        enADJ,
  input  logic        hours12_24,
  input  logic [15:0] adjC12_IN,
  input  logic [15:0] adjC24_IN,
  input  logic [15:0] adjA12_IN,
  input  logic [15:0] adjA24_IN,
  input  logic        alarm_en,
  input  logic        stop_p,
  input  logic        snooze_p,
  output logic [15:0] dataC12_OUT,
  output logic [15:0] dataC24_OUT,
  output logic [15:0] dataA12_OUT,
  output logic [15:0] dataA24_OUT,
  output logic [5:0]  sec,
  output logic        pmC,
  output logic        pmA,
  output logic        tick_1hz,
  output logic        buzz
);

  localparam int PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PRESC_TOP   = PW'(CLK_HZ - 1);
  localparam logic [CW-1:0] RING_TOP    = CW'(RING_SEC);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC);

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } alarmState_e;

  function automatic logic [5:0] clampMin(input logic [7:0] v);
    return (v > 8'd59) ? 6'd59 : v[5:0];
  endfunction

  function automatic logic [4:0] clampHr24(input logic [7:0] v);
    return (v > 8'd23) ? 5'd23 : v[4:0];
  endfunction

  // 12 h adjust values keep the AM/PM half the register held before adjusting.
  function automatic logic [4:0] hr12To24(input logic [7:0] v, input logic pm);
    logic [4:0] h;
    h = (v > 8'd11) ? 5'd11 : v[4:0];
    return pm ? (h + 5'd12) : h;
  endfunction

  function automatic logic [4:0] to12(input logic [4:0] h);
    return (h >= 5'd12) ? (h - 5'd12) : h;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    almMin_q, almMin_d;
  logic [4:0]    almHr_q, almHr_d;
  logic          enAdj_q;
  alarmState_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic loadCycle;
  logic adjRise;
  logic tick;
  logic ringHit;

  always_comb begin
    loadCycle = enAdj_q & ~enADJ;
    adjRise   = ~enAdj_q & enADJ;
    tick      = ~enADJ & ~loadCycle & (presc_q == PRESC_TOP);
    presc_d   = (enADJ | loadCycle | tick) ? '0 : presc_q + PW'(1);

    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    almMin_d = almMin_q;
    almHr_d  = almHr_q;

    if (loadCycle) begin
      if (hours12_24) begin
        hr_d     = hr12To24(adjC12_IN[15:8], hr_q >= 5'd12);
        min_d    = clampMin(adjC12_IN[7:0]);
        almHr_d  = hr12To24(adjA12_IN[15:8], almHr_q >= 5'd12);
        almMin_d = clampMin(adjA12_IN[7:0]);
      end else begin
        hr_d     = clampHr24(adjC24_IN[15:8]);
        min_d    = clampMin(adjC24_IN[7:0]);
        almHr_d  = clampHr24(adjA24_IN[15:8]);
        almMin_d = clampMin(adjA24_IN[7:0]);
      end
      sec_d = '0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Ring starts only on a tick that rolls into second 0 of the alarm minute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ringHit = tick & (sec_d == 6'd0) & (hr_d == almHr_q) & (min_d == almMin_q);

    if (!alarm_en || adjRise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ringHit) begin
            state_d = RING;
            cnt_d   = '0;
          end
        end
        RING: begin
          if (stop_p) begin
            state_d = IDLE;
          end else if (snooze_p) begin
            state_d = SNOOZE;
            cnt_d   = SNOOZE_LOAD;
          end else if (tick) begin
            if (cnt_q + CW'(1) == RING_TOP) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        SNOOZE: begin
          if (stop_p) begin
            state_d = IDLE;
          end else if (tick) begin
            if (cnt_q <= CW'(1)) begin
              state_d = RING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      presc_q  <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hr_q     <= '0;
      almMin_q <= 6'd59;
      almHr_q  <= 5'd23;
      enAdj_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      almMin_q <= almMin_d;
      almHr_q  <= almHr_d;
      enAdj_q  <= enADJ;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are registered from next-state values so they align with the state.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      dataC24_OUT <= 16'h0000;
      dataC12_OUT <= 16'h0000;
      dataA24_OUT <= {8'd23, 8'd59};
      dataA12_OUT <= {8'd11, 8'd59};
      sec         <= '0;
      pmC         <= 1'b0;
      pmA         <= 1'b1;
      tick_1hz    <= 1'b0;
      buzz        <= 1'b0;
    end else begin
      dataC24_OUT <= {3'b000, hr_d, 2'b00, min_d};
      dataC12_OUT <= {3'b000, to12(hr_d), 2'b00, min_d};
      dataA24_OUT <= {3'b000, almHr_d, 2'b00, almMin_d};
      dataA12_OUT <= {3'b000, to12(almHr_d), 2'b00, almMin_d};
      sec         <= sec_d;
      pmC         <= (hr_d >= 5'd12);
      pmA         <= (almHr_d >= 5'd12);
      tick_1hz    <= tick;
      buzz        <= (state_d == RING);
    end
  end

endmodule

// File: tb/tb_timekeeper_core.sv
// Bench for timekeeper_core: directed and random steps compared every cycle
// against a time-of-day (seconds) reference model of the clock and alarm.
module tb_timekeeper_core;

  localparam int CLK_HZ     = 4;
  localparam int RING_SEC   = 5;
  localparam int SNOOZE_SEC = 7;
  localparam int M_IDLE   = 0;
  localparam int M_RING   = 1;
  localparam int M_SNOOZE = 2;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        enADJ = 1'b0;
  logic        hours12_24 = 1'b0;
  logic [15:0] adjC12_IN = '0;
  logic [15:0] adjC24_IN = '0;
  logic [15:0] adjA12_IN = '0;
  logic [15:0] adjA24_IN = '0;
  logic        alarm_en = 1'b0;
  logic        stop_p = 1'b0;
  logic        snooze_p = 1'b0;
  logic [15:0] dataC12_OUT, dataC24_OUT, dataA12_OUT, dataA24_OUT;
  logic [5:0]  sec;
  logic        pmC, pmA, tick_1hz, buzz;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: seconds of day, alarm minute of day, cycle phase in second.
  int mTod, mAlarm, mPhase, mMode, mRingSecs, mSnoozeLeft;
  bit mPrevAdj, mTick;

  timekeeper_core #(
    .CLK_HZ(CLK_HZ),
    .RING_SEC(RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .enADJ(enADJ),
    .hours12_24(hours12_24),
    .adjC12_IN(adjC12_IN),
    .adjC24_IN(adjC24_IN),
    .adjA12_IN(adjA12_IN),
    .adjA24_IN(adjA24_IN),
    .alarm_en(alarm_en),
    .stop_p(stop_p),
    .snooze_p(snooze_p),
    .dataC12_OUT(dataC12_OUT),
    .dataC24_OUT(dataC24_OUT),
    .dataA12_OUT(dataA12_OUT),
    .dataA24_OUT(dataA24_OUT),
    .sec(sec),
    .pmC(pmC),
    .pmA(pmA),
    .tick_1hz(tick_1hz),
    .buzz(buzz)
  );

  always #5 clk = ~clk;

  function automatic int clampTo(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic modelReset();
    mTod = 0;
    mAlarm = 23 * 60 + 59;
    mPhase = 0;
    mMode = M_IDLE;
    mRingSecs = 0;
    mSnoozeLeft = 0;
    mPrevAdj = 1'b0;
    mTick = 1'b0;
  endtask

  task automatic modelStep();
    bit loadNow, rise;
    int h, m, ah, am;
    loadNow = mPrevAdj && !enADJ;
    rise = !mPrevAdj && enADJ;
    mTick = 1'b0;
    if (enADJ) begin
      mPhase = 0;
    end else if (loadNow) begin
      if (hours12_24) begin
        h  = clampTo(int'(adjC12_IN[15:8]), 11) + ((mTod / 3600 >= 12) ? 12 : 0);
        m  = clampTo(int'(adjC12_IN[7:0]), 59);
        ah = clampTo(int'(adjA12_IN[15:8]), 11) + ((mAlarm / 60 >= 12) ? 12 : 0);
        am = clampTo(int'(adjA12_IN[7:0]), 59);
      end else begin
        h  = clampTo(int'(adjC24_IN[15:8]), 23);
        m  = clampTo(int'(adjC24_IN[7:0]), 59);
        ah = clampTo(int'(adjA24_IN[15:8]), 23);
        am = clampTo(int'(adjA24_IN[7:0]), 59);
      end
      mTod = h * 3600 + m * 60;
      mAlarm = ah * 60 + am;
      mPhase = 0;
    end else if (mPhase == CLK_HZ - 1) begin
      mPhase = 0;
      mTod = (mTod + 1) % 86400;
      mTick = 1'b1;
    end else begin
      mPhase++;
    end
    mPrevAdj = enADJ;

    if (!alarm_en || rise) begin
      mMode = M_IDLE;
    end else if (mMode == M_IDLE) begin
      if (mTick && (mTod % 60 == 0) && (mTod / 60 == mAlarm)) begin
        mMode = M_RING;
        mRingSecs = 0;
      end
    end else if (mMode == M_RING) begin
      if (stop_p) mMode = M_IDLE;
      else if (snooze_p) begin
        mMode = M_SNOOZE;
        mSnoozeLeft = SNOOZE_SEC;
      end else if (mTick) begin
        mRingSecs++;
        if (mRingSecs == RING_SEC) mMode = M_IDLE;
      end
    end else begin
      if (stop_p) mMode = M_IDLE;
      else if (mTick) begin
        mSnoozeLeft--;
        if (mSnoozeLeft == 0) begin
          mMode = M_RING;
          mRingSecs = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int h24, mn, s, ah, am;
    h24 = mTod / 3600;
    mn  = (mTod / 60) % 60;
    s   = mTod % 60;
    ah  = mAlarm / 60;
    am  = mAlarm % 60;
    check("clock24", 32'(dataC24_OUT), 32'({8'(h24), 8'(mn)}));
    check("clock12", 32'(dataC12_OUT), 32'({8'(h24 % 12), 8'(mn)}));
    check("seconds", 32'(sec), 32'(s));
    check("pmC", 32'(pmC), 32'(h24 >= 12));
    check("alarm24", 32'(dataA24_OUT), 32'({8'(ah), 8'(am)}));
    check("alarm12", 32'(dataA12_OUT), 32'({8'(ah % 12), 8'(am)}));
    check("pmA", 32'(pmA), 32'(ah >= 12));
    check("tick", 32'(tick_1hz), 32'(mTick));
    check("buzz", 32'(buzz), 32'(mMode == M_RING));
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  task automatic setAdj(input int ch, input int cm, input int ah, input int am);
    adjC12_IN = {8'(ch), 8'(cm)};
    adjC24_IN = {8'(ch), 8'(cm)};
    adjA12_IN = {8'(ah), 8'(am)};
    adjA24_IN = {8'(ah), 8'(am)};
  endtask

  task automatic loadAdjust(input int holdCycles);
    enADJ = 1'b1;
    applyStimulus(holdCycles);
    enADJ = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    RESET = 1'b1;

    applyStimulus(4);
    check("firstSecond", 32'(sec), 32'd1);

    setAdj(23, 59, 23, 59);
    loadAdjust(3);
    applyStimulus(60 * CLK_HZ);
    check("midnightWrap", 32'(dataC24_OUT), 32'h0000);
    applyStimulus(2);

    setAdj(14, 5, 23, 59);
    loadAdjust(2);
    hours12_24 = 1'b1;
    setAdj(3, 20, 11, 59);
    loadAdjust(2);
    check("pmKeptLoad", 32'(dataC24_OUT), 32'({8'd15, 8'd20}));
    applyStimulus(6);

    for (int i = 0; i < 10; i++) begin
      hours12_24 = 1'($urandom_range(0, 1));
      adjC12_IN = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 70))};
      adjC24_IN = {8'($urandom_range(0, 30)), 8'($urandom_range(0, 70))};
      adjA12_IN = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 70))};
      adjA24_IN = {8'($urandom_range(0, 30)), 8'($urandom_range(0, 70))};
      loadAdjust($urandom_range(1, 20));
      applyStimulus($urandom_range(5, 40));
    end

    hours12_24 = 1'b0;
    setAdj(7, 29, 7, 30);
    alarm_en = 1'b1;
    loadAdjust(2);
    applyStimulus(60 * CLK_HZ);
    check("ringStart", 32'(buzz), 32'd1);
    applyStimulus((RING_SEC + 3) * CLK_HZ);

    loadAdjust(2);
    applyStimulus(62 * CLK_HZ);
    snooze_p = 1'b1;
    applyStimulus(1);
    snooze_p = 1'b0;
    applyStimulus((SNOOZE_SEC + 2) * CLK_HZ);
    stop_p = 1'b1;
    snooze_p = 1'b1;
    applyStimulus(1);
    stop_p = 1'b0;
    snooze_p = 1'b0;
    check("stopWins", 32'(buzz), 32'd0);
    applyStimulus(8);

    loadAdjust(2);
    applyStimulus(61 * CLK_HZ);
    enADJ = 1'b1;
    applyStimulus(20);
    enADJ = 1'b0;
    applyStimulus(4);

    applyStimulus(61 * CLK_HZ);
    alarm_en = 1'b0;
    applyStimulus(3);
    alarm_en = 1'b1;
    applyStimulus(8);

    for (int r = 0; r < 3; r++) begin
      loadAdjust(2);
      for (int i = 0; i < 80 * CLK_HZ; i++) begin
        stop_p   = ($urandom_range(0, 79) == 0);
        snooze_p = ($urandom_range(0, 29) == 0);
        alarm_en = ($urandom_range(0, 199) != 0);
        applyStimulus(1);
      end
      stop_p = 1'b0;
      snooze_p = 1'b0;
      alarm_en = 1'b1;
    end

    loadAdjust(2);
    applyStimulus(61 * CLK_HZ);
    check("ringBeforeReset", 32'(buzz), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("asyncBuzzDrop", 32'(buzz), 32'd0);
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    RESET = 1'b1;
    applyStimulus(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
